nrdiv: RTL and testbench
========================

# nrdiv

Unsigned non-restoring divider, the inverse companion to the team's Booth radix-4 multiplier device. It shares that device's byte-serial bus protocol. A 2·WIDTH-bit dividend and a WIDTH-bit divisor are loaded over `inbus`; the remainder and then the quotient are returned on `outbus`. It sits beside the multiplier in the multiplication/division device set and is driven by the same sequencing host.

## Interface
- `WIDTH`, default 8: bus width, divisor/quotient/remainder width, and iteration count.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `enable` input 1: start request, sampled only in IDLE.
- `inbus` input WIDTH: operand bytes, unsigned.
- `done` output 1: result valid on `outbus`.
- `outbus` output WIDTH: remainder, then quotient.
- `err` output 1: only present with `NRDIV_ERR_EN`. Signals divide-by-zero or quotient overflow.

## Operation
- States: IDLE, LD_HI, LD_LO, ITER, FIX, OUT_R, OUT_Q.
- **IDLE**
  - On `enable`=1: M ← `inbus` (divisor); go to LD_HI.
  - `enable` is ignored in all other states.
- **LD_HI:** A ← {1'b0, `inbus`} (dividend high). Go to LD_LO.
- **LD_LO:** Q ← `inbus` (dividend low). Clear the iteration counter. Go to ITER.
- **ITER**, repeated WIDTH times, counted by a $clog2(WIDTH)-bit counter:
  - Shift {A,Q} left by 1.
  - If the pre-shift A[WIDTH] is 1, then A ← A + M; otherwise A ← A − M.
  - Q[0] ← ~A_new[WIDTH].
  - Go to FIX after the WIDTH-th iteration.
- **FIX:** if A[WIDTH] is 1, then A ← A + M. Go to OUT_R.
- **OUT_R:** `done`=1, `outbus`=A[WIDTH-1:0] (remainder). Go to OUT_Q.
- **OUT_Q:** `done`=1, `outbus`=Q (quotient). Go to IDLE.
- Arithmetic:
  - A is WIDTH+1 bits, two's complement.
  - Subtraction is M zero-extended, XOR-inverted, with carry-in 1.
  - Carry-out is discarded.
- Results are exact when dividend_hi < M.
- `outbus` is 0 whenever `done`=0. There is no tri-state on the output.

## Timing
- Cycle 0 is the cycle in which IDLE samples `enable`=1.
- Cycle 1 is LD_HI, cycle 2 is LD_LO, and cycles 3 to WIDTH+2 are ITER.
- Cycle WIDTH+3 is FIX.
- Cycle WIDTH+4 is OUT_R and cycle WIDTH+5 is OUT_Q.
- With WIDTH=8, `done` is high in cycles 12 and 13 only.
- IDLE is re-entered at cycle WIDTH+6, which can immediately accept a new `enable`. Back-to-back operations have no dead cycle.
- `done` and `outbus` are registered outputs.
- `rst` asserted at any time, including mid-ITER:
  - State goes to IDLE.
  - A, Q, M, the counter, `done`, `outbus` and `err` all go to 0.
  - The in-flight operation is discarded with no partial output.
- Reset values: `done`=0, `outbus`=0, `err`=0.

## Configuration
- `NRDIV_ERR_EN` defined:
  - The `err` port exists.
  - On the LD_LO exit edge, the block checks dividend_hi (A) ≥ M. This also covers M=0.
  - If the check is true, ITER and FIX are skipped and the block goes to OUT_R.
  - The remainder and quotient are forced to all-ones.
  - `err`=1 during OUT_R and OUT_Q, and 0 otherwise.
  - With WIDTH=8, `done` is then high in cycles 3 and 4.
- `NRDIV_ERR_EN` undefined:
  - There is no `err` port and no check.
  - Overflow operands run the full sequence with normal timing.
  - The `outbus` values for overflow operands are unspecified, but `done` must still pulse in cycles WIDTH+4 and WIDTH+5.

## Structure
- Package `nrdiv_pkg` holds:
  - the state enum typedef;
  - the default-width localparam;
  - the output-select encoding.
- Sub-module `nrdiv_addsub`: a (WIDTH+1)-bit adder/subtractor with XOR-invert and carry-in, selected by a `sub` control.
- Control FSM, counter and datapath registers live in `nrdiv`.

## Test plan
- 1000/7 (`inbus` 0x07, 0x03, 0xE8) → `outbus` 0x06 in cycle 12, then 0x8E in cycle 13; `done` high in those cycles only.
- 0x0000/0x05 → remainder 0x00, quotient 0x00.
- 0xFEFF/0xFF → remainder 0xFE, quotient 0xFF. This is the maximum legal quotient.
- With `NRDIV_ERR_EN`, 0x1234/0x00 → `err`=1 and `outbus` 0xFF, 0xFF in cycles 3 and 4. 0x0512/0x05 errors the same way.
- Reset and idle-ignore sequence:
  - Assert `rst` in cycle 6 of an operation → `done`/`outbus` are 0 immediately.
  - Then run 100/3 → remainder 0x01, quotient 0x21.
  - `enable` pulses during ITER are ignored.
- Back-to-back:
  - Assert `enable` again in cycle 14 with 50/6 → the new operation starts with no gap.
  - Results: remainder 0x02, quotient 0x08, with `done` in cycles 26–27.

Source files
------------

// File: rtl/nrdiv_pkg.sv
// Shared types for the nrdiv unsigned non-restoring divider: FSM states,
// default width and the output-select encoding.
package nrdiv_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LD_HI = 3'd1,
        LD_LO = 3'd2,
        ITER  = 3'd3,
        FIX   = 3'd4,
        OUT_R = 3'd5,
        OUT_Q = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        OSEL_ZERO = 2'd0,
        OSEL_REM  = 2'd1,
        OSEL_QUO  = 2'd2,
        OSEL_ONES = 2'd3
    } osel_e;

endpackage

// File: rtl/nrdiv_if.sv
// Byte-serial host bus of the divider. The err signal only exists when
// NRDIV_ERR_EN is defined.
interface nrdiv_if #(
    parameter int WIDTH = nrdiv_pkg::DEFAULT_WIDTH
) ();
    // Protocol: host raises enable for one cycle with the divisor on inbus while
    // the device is idle, then presents dividend high and low bytes on the next
    // two cycles. There is no ready: the device answers after a fixed latency with
    // done high for two cycles (remainder, then quotient); outbus is 0 otherwise.
    logic             enable;
    logic [WIDTH-1:0] inbus;
    logic             done;
    logic [WIDTH-1:0] outbus;
`ifdef NRDIV_ERR_EN
    logic             err;

    modport master (output enable, output inbus, input done, input outbus, input err);
    modport slave  (input enable, input inbus, output done, output outbus, output err);
`else
    modport master (output enable, output inbus, input done, input outbus);
    modport slave  (input enable, input inbus, output done, output outbus);
`endif
endinterface

// File: rtl/nrdiv_addsub.sv
// (N)-bit adder/subtractor: y = a + (b ^ {N{sub}}) + sub, carry-out dropped.
module nrdiv_addsub #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] y
);
    assign y = a + (b ^ {N{sub}}) + {{(N-1){1'b0}}, sub};
endmodule

// File: rtl/nrdiv.sv
// Unsigned non-restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor.
// Optional NRDIV_ERR_EN adds an err output and an early overflow/zero-divisor exit.
module nrdiv
    import nrdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic   clk,
    input  logic   rst,
    nrdiv_if.slave bus,
    output state_e dbg_state
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] out_q, out_d;
    osel_e            osel;

    logic [WIDTH:0]   as_a, as_b, as_y;
    logic             as_sub;
    logic [WIDTH:0]   a_shift;

`ifdef NRDIV_ERR_EN
    logic err_q, err_d;
    logic ovf;
    // Quotient fits in WIDTH bits only when dividend_hi < divisor; also traps M=0.
    assign ovf = (a_q[WIDTH-1:0] >= m_q);
`endif

    assign a_shift = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign as_a    = (state_q == FIX) ? a_q : a_shift;
    assign as_b    = {1'b0, m_q};
    assign as_sub  = (state_q == FIX) ? 1'b0 : ~a_q[WIDTH];

    nrdiv_addsub #(.N(WIDTH + 1)) u_addsub (
        .a   (as_a),
        .b   (as_b),
        .sub (as_sub),
        .y   (as_y)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        osel    = OSEL_ZERO;
`ifdef NRDIV_ERR_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    m_d     = bus.inbus;
                    state_d = LD_HI;
                end
            end
            LD_HI: begin
                a_d     = {1'b0, bus.inbus};
                state_d = LD_LO;
            end
            LD_LO: begin
                q_d     = bus.inbus;
                cnt_d   = '0;
                state_d = ITER;
`ifdef NRDIV_ERR_EN
                if (ovf) begin
                    a_d     = {1'b0, {WIDTH{1'b1}}};
                    q_d     = '1;
                    state_d = OUT_R;
                    done_d  = 1'b1;
                    osel    = OSEL_ONES;
                    err_d   = 1'b1;
                end
`endif
            end
            ITER: begin
                a_d   = as_y;
                q_d   = {q_q[WIDTH-2:0], ~as_y[WIDTH]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (a_q[WIDTH]) begin
                    a_d = as_y;
                end
                state_d = OUT_R;
                done_d  = 1'b1;
                osel    = OSEL_REM;
            end
            OUT_R: begin
                state_d = OUT_Q;
                done_d  = 1'b1;
                osel    = OSEL_QUO;
`ifdef NRDIV_ERR_EN
                err_d   = err_q;
`endif
            end
            OUT_Q: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register is loaded one cycle ahead so done/outbus line up with OUT_R/OUT_Q.
    always_comb begin
        case (osel)
            OSEL_REM:  out_d = a_d[WIDTH-1:0];
            OSEL_QUO:  out_d = q_q;
            OSEL_ONES: out_d = '1;
            default:   out_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            out_q   <= '0;
`ifdef NRDIV_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            out_q   <= out_d;
`ifdef NRDIV_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign bus.done   = done_q;
    assign bus.outbus = out_q;
`ifdef NRDIV_ERR_EN
    assign bus.err    = err_q;
`endif
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_nrdiv.sv
// Self-checking bench for nrdiv: arithmetic reference model, per-cycle compare
// of done/outbus(/err), directed literal cases, reset and back-to-back cases.
module tb_nrdiv;
    import nrdiv_pkg::*;

    localparam int W = 8;
`ifdef NRDIV_ERR_EN
    localparam bit ERR_BUILD = 1'b1;
`else
    localparam bit ERR_BUILD = 1'b0;
`endif

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    state_e dbg_state;

    nrdiv_if #(.WIDTH(W)) bus ();

    nrdiv #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    bit           exp_care_q[$];
    bit           exp_err_q[$];
    logic [W-1:0] prev_out = '0;
    logic [W-1:0] last_out = '0;
    bit           chk_on   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flush_sb();
        exp_q.delete();
        exp_cyc_q.delete();
        exp_care_q.delete();
        exp_err_q.delete();
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
                chk("done_hi", 32'(bus.done), 32'(1));
                if (exp_care_q[0]) chk("outbus", 32'(bus.outbus), 32'(exp_q[0]));
`ifdef NRDIV_ERR_EN
                chk("err_in_out", 32'(bus.err), 32'(exp_err_q[0]));
`endif
                prev_out <= last_out;
                last_out <= bus.outbus;
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
                void'(exp_care_q.pop_front());
                void'(exp_err_q.pop_front());
            end else begin
                chk("done_lo", 32'(bus.done), 32'(0));
                chk("outbus_idle", 32'(bus.outbus), 32'(0));
`ifdef NRDIV_ERR_EN
                chk("err_idle", 32'(bus.err), 32'(0));
`endif
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic bit model(input logic [W-1:0] m, input logic [2*W-1:0] dvd,
                                 output logic [W-1:0] rem, output logic [W-1:0] quo);
        int unsigned dv, mv;
        dv = 32'(dvd);
        mv = 32'(m);
        if (mv == 0 || (dv >> W) >= mv) begin
            rem = '1;
            quo = '1;
            return 1'b1;
        end
        rem = W'(dv % mv);
        quo = W'(dv / mv);
        return 1'b0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives the three load cycles and books the expected result cycles.
    task automatic launch(input logic [W-1:0] m, input logic [2*W-1:0] dvd, output int p_end);
        logic [W-1:0] rem, quo;
        bit ovf;
        int p, lat;
        ovf = model(m, dvd, rem, quo);
        p   = cyc;
        lat = (ERR_BUILD && ovf) ? 3 : W + 4;
        exp_cyc_q.push_back(p + lat);
        exp_q.push_back(rem);
        exp_care_q.push_back(ERR_BUILD || !ovf);
        exp_err_q.push_back(ERR_BUILD && ovf);
        exp_cyc_q.push_back(p + lat + 1);
        exp_q.push_back(quo);
        exp_care_q.push_back(ERR_BUILD || !ovf);
        exp_err_q.push_back(ERR_BUILD && ovf);
        p_end = p + lat + 2;
        bus.enable = 1'b1;
        bus.inbus  = m;
        step();
        bus.enable = 1'b0;
        bus.inbus  = dvd[2*W-1:W];
        step();
        bus.inbus  = dvd[W-1:0];
        step();
        bus.inbus  = W'($urandom);
    endtask

    task automatic wait_until(input int p_end, input bit pulse);
        while (cyc < p_end) begin
            if (pulse && cyc < p_end - 4) begin
                bus.enable = 1'($urandom_range(0, 1));
                bus.inbus  = W'($urandom);
            end else begin
                bus.enable = 1'b0;
            end
            step();
        end
        bus.enable = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] m, input logic [2*W-1:0] dvd, input bit pulse);
        int p_end;
        launch(m, dvd, p_end);
        wait_until(p_end, pulse);
    endtask

    task automatic check_pair(input string name, input logic [W-1:0] rem, input logic [W-1:0] quo);
        chk({name, "_rem"}, 32'(prev_out), 32'(rem));
        chk({name, "_quo"}, 32'(last_out), 32'(quo));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int p_end;
        logic [W-1:0] m, hi, lo;

        bus.enable = 1'b0;
        bus.inbus  = '0;
        #1;
        rst = 1'b1;
        #1;
        chk("reset_done", 32'(bus.done), 32'(0));
        chk("reset_outbus", 32'(bus.outbus), 32'(0));
        chk("reset_state", 32'(dbg_state), 32'(IDLE));
`ifdef NRDIV_ERR_EN
        chk("reset_err", 32'(bus.err), 32'(0));
`endif
        step();
        step();
        rst = 1'b0;
        chk_on = 1'b1;
        step();

        run_op(8'h07, 16'd1000, 1'b0);
        check_pair("d1000_7", 8'h06, 8'h8E);
        run_op(8'h05, 16'h0000, 1'b0);
        check_pair("d0_5", 8'h00, 8'h00);
        run_op(8'hFF, 16'hFEFF, 1'b0);
        check_pair("dFEFF_FF", 8'hFE, 8'hFF);

        run_op(8'h00, 16'h1234, 1'b0);
`ifdef NRDIV_ERR_EN
        check_pair("div_zero", 8'hFF, 8'hFF);
`endif
        run_op(8'h05, 16'h0512, 1'b0);
`ifdef NRDIV_ERR_EN
        check_pair("ovf_0512_5", 8'hFF, 8'hFF);
`endif

        // Reset in cycle 6 of an operation.
        launch(8'h07, 16'd1000, p_end);
        step();
        step();
        step();
        rst = 1'b1;
        flush_sb();
        #1;
        chk("rst_mid_done", 32'(bus.done), 32'(0));
        chk("rst_mid_outbus", 32'(bus.outbus), 32'(0));
        chk("rst_mid_state", 32'(dbg_state), 32'(IDLE));
        step();
        rst = 1'b0;
        step();

        // Reset while the remainder is on the bus.
        launch(8'h09, 16'd500, p_end);
        while (cyc < p_end - 2) step();
        rst = 1'b1;
        flush_sb();
        #1;
        chk("rst_outr_done", 32'(bus.done), 32'(0));
        chk("rst_outr_outbus", 32'(bus.outbus), 32'(0));
        step();
        rst = 1'b0;
        step();

        run_op(8'h03, 16'd100, 1'b1);
        check_pair("d100_3", 8'h01, 8'h21);

        // Back-to-back: second enable lands on the first IDLE cycle.
        run_op(8'h07, 16'd1000, 1'b0);
        run_op(8'h06, 16'd50, 1'b0);
        check_pair("b2b_50_6", 8'h02, 8'h08);

        for (int i = 0; i < 80; i++) begin
            m  = W'($urandom_range(1, 255));
            hi = W'($urandom_range(0, int'(m) - 1));
            lo = W'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                hi = W'($urandom_range(int'(m), 255));
                if ($urandom_range(0, 1) == 0) m = '0;
            end
            run_op(m, {hi, lo}, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) step();
        end

        step();
        step();
        step();
        chk("sb_drained", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 50000", cyc);
        $fatal(1);
    end

endmodule
